// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter/sequencer in front of a single-port data memory.
// Optional address range checking (err0/err1 outputs) is enabled by defining DMEM_ARB_BOUNDS_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int MEM_AW = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_BOUNDS_EN
    output logic              err0,
    output logic              err1,
`endif
    output logic              busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_r;
    logic                last_r;      // port that won the most recent grant
    logic                op_port_r;
    logic                op_we_r;
    logic [ADDR_W-1:0]   op_addr_r;
    logic [DATA_W-1:0]   op_wdata_r;
    logic                grant0_s;
    logic                grant1_s;
    logic                op_oob_s;
    logic                in_range_s;
    logic                in_access_s;

    // Grant selection: only in IDLE and never while reset is asserted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && (state_r == IDLE)) begin
            if (req0 && req1) begin
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0) begin
                grant0_s = 1'b1;
            end else if (req1) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign op_oob_s = |op_addr_r[ADDR_W-1:MEM_AW];

`ifdef DMEM_ARB_BOUNDS_EN
    assign in_range_s = !op_oob_s;
`else
    logic unused_oob_s;
    assign unused_oob_s = op_oob_s;
    assign in_range_s   = 1'b1;
`endif

    // Memory strobes are live only in ACCESS, and are forced off during reset so an interrupted write cannot commit.
    assign in_access_s = !rst && (state_r == ACCESS) && in_range_s;
    assign mem_write   = in_access_s && op_we_r;
    assign mem_read    = in_access_s && !op_we_r;
    assign mem_addr    = op_addr_r[MEM_AW-1:0];
    assign mem_wdata   = op_wdata_r;
    assign gnt0        = grant0_s;
    assign gnt1        = grant1_s;
    assign busy        = (state_r == ACCESS);

    // Sequencer FSM: latch the winning request in IDLE, perform the access and return read data in ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            op_port_r  <= 1'b0;
            op_we_r    <= 1'b0;
            op_addr_r  <= {ADDR_W{1'b0}};
            op_wdata_r <= {DATA_W{1'b0}};
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= {DATA_W{1'b0}};
            rdata1     <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_BOUNDS_EN
            err0       <= 1'b0;
            err1       <= 1'b0;
`endif
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
`ifdef DMEM_ARB_BOUNDS_EN
            err0    <= 1'b0;
            err1    <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_port_r  <= grant1_s;
                        last_r     <= grant1_s;
                        op_we_r    <= grant1_s ? we1 : we0;
                        op_addr_r  <= grant1_s ? addr1 : addr0;
                        op_wdata_r <= grant1_s ? wdata1 : wdata0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r <= IDLE;
                    // Out-of-range reads still complete, returning zero.
                    if (!op_we_r) begin
                        if (op_port_r) begin
                            rvalid1 <= 1'b1;
                            rdata1  <= in_range_s ? mem_rdata : {DATA_W{1'b0}};
                        end else begin
                            rvalid0 <= 1'b1;
                            rdata0  <= in_range_s ? mem_rdata : {DATA_W{1'b0}};
                        end
                    end else begin
                        rvalid0 <= 1'b0;
                        rvalid1 <= 1'b0;
                    end
`ifdef DMEM_ARB_BOUNDS_EN
                    if (!in_range_s) begin
                        if (op_port_r) begin
                            err1 <= 1'b1;
                        end else begin
                            err0 <= 1'b1;
                        end
                    end else begin
                        err0 <= 1'b0;
                        err1 <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences and a randomized model check.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int MEM_AW = 6;
    localparam int DATA_W = 32;
`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_read, mem_write, busy;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_BOUNDS_EN
    logic              err0, err1;
`endif

    logic [DATA_W-1:0] mem [64];
    logic              pl_en = 1'b0;
    logic [MEM_AW-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_BOUNDS_EN
        .err0(err0), .err1(err1),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: async read, write on rising edge; the bench preloads through a side port.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    // Leaves the bench one time unit after a rising edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    typedef struct {
        logic        r0, w0; logic [7:0] a0; logic [31:0] d0;
        logic        r1, w1; logic [7:0] a1; logic [31:0] d1;
        logic        g0, g1, v0, v1;
        logic [31:0] rd0, rd1;
        logic        mw, mr, bz;
    } vec_t;

    vec_t tbl [20];

    // Random-phase reference model state
    logic [31:0] shadow [64];
    bit          q_req [2];
    bit          q_we [2];
    logic [7:0]  q_addr [2];
    logic [31:0] q_wd [2];

    initial begin
        logic        wb6;
        logic [31:0] rd9;
        bit          m_busy, m_we, in_r;
        int          m_port, m_last, win;
        logic [7:0]  m_addr;
        logic [31:0] m_wd;
        bit          m_rv [2];
        bit          m_err [2];
        logic [31:0] m_rd [2];

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload(6'd0, 32'd1);
        preload(6'd1, 32'd7);
        preload(6'd5, 32'd0);

        // Contention from reset release: both ports reading, held high throughout.
        req0 = 1'b1; addr0 = 8'd0; req1 = 1'b1; addr1 = 8'd1;
        @(negedge clk);
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk32("rst_rdata0", rdata0, 32'd0);
        chk32("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk1("alt_gnt0", gnt0, (k % 4) == 0);
            chk1("alt_gnt1", gnt1, (k % 4) == 2);
            chk1("alt_rvalid0", rvalid0, (k % 4) == 2);
            chk1("alt_rvalid1", rvalid1, ((k % 4) == 0) && (k >= 4));
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        chk1("alt_last_rvalid1", rvalid1, 1'b1);
        chk32("alt_rdata0", rdata0, 32'd1);
        chk32("alt_rdata1", rdata1, 32'd7);
        @(posedge clk);
        #1;

        // Directed vector table, starting in IDLE right after reset.
        wb6 = BOUNDS ? 1'b0 : 1'b1;
        rd9 = BOUNDS ? 32'hDEADBEEF : 32'h11;
        tbl[0]  = '{1'b1,1'b1,8'h05,32'hDEADBEEF, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b1,1'b0,1'b1};
        tbl[2]  = '{1'b1,1'b0,8'h05,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1,1'b1};
        tbl[4]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0, 1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,8'h45,32'h11, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0, 1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0, wb6,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,8'h05,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0, 1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0, 1'b0,1'b1,1'b1};
        tbl[9]  = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h01,32'h0, 1'b0,1'b1,1'b1,1'b0, rd9,32'h0, 1'b0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, rd9,32'h0, 1'b0,1'b1,1'b1};
        tbl[11] = '{1'b1,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b1, rd9,32'h7, 1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, rd9,32'h7, 1'b0,1'b1,1'b1};
        tbl[13] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h00,32'h0, 1'b0,1'b1,1'b1,1'b0, 32'h1,32'h7, 1'b0,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h1,32'h7, 1'b0,1'b1,1'b1};
        tbl[15] = '{1'b1,1'b0,8'h01,32'h0, 1'b1,1'b0,8'h01,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h1,32'h1, 1'b0,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h01,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h1,32'h1, 1'b0,1'b1,1'b1};
        tbl[17] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h01,32'h0, 1'b0,1'b1,1'b1,1'b0, 32'h7,32'h1, 1'b0,1'b0,1'b0};
        tbl[18] = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h7,32'h1, 1'b0,1'b1,1'b1};
        tbl[19] = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b1, 32'h7,32'h7, 1'b0,1'b0,1'b0};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            @(negedge clk);
            chk1($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
            chk1($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
            chk1($sformatf("v%0d_rvalid0", i), rvalid0, tbl[i].v0);
            chk1($sformatf("v%0d_rvalid1", i), rvalid1, tbl[i].v1);
            chk32($sformatf("v%0d_rdata0", i), rdata0, tbl[i].rd0);
            chk32($sformatf("v%0d_rdata1", i), rdata1, tbl[i].rd1);
            chk1($sformatf("v%0d_mem_write", i), mem_write, tbl[i].mw);
            chk1($sformatf("v%0d_mem_read", i), mem_read, tbl[i].mr);
            chk1($sformatf("v%0d_busy", i), busy, tbl[i].bz);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        chk32("wrap_mem5", mem[5], BOUNDS ? 32'hDEADBEEF : 32'h11);

        // Reset asserted during the ACCESS cycle of a port 1 write.
        preload(6'd3, 32'hA5A5A5A5);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd3; wdata1 = 32'h55;
        @(negedge clk);
        chk1("rw_gnt1", gnt1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1; idle_inputs();
        @(negedge clk);
        chk1("rw_mem_write", mem_write, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rw_busy", busy, 1'b0);
        chk1("rw_rvalid0", rvalid0, 1'b0);
        chk1("rw_rvalid1", rvalid1, 1'b0);
        chk32("rw_rdata0", rdata0, 32'd0);
        chk32("rw_rdata1", rdata1, 32'd0);
        chk32("rw_mem_addr", 32'(mem_addr), 32'd0);
        chk32("rw_mem_wdata", mem_wdata, 32'd0);
        chk32("rw_mem3", mem[3], 32'hA5A5A5A5);
        @(posedge clk);
        #1;

`ifdef DMEM_ARB_BOUNDS_EN
        // Out-of-range read follows an in-range read so rdata0 is seen to drop to zero.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
        @(negedge clk); chk1("oob_pre_gnt0", gnt0, 1'b1);
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h45;
        @(negedge clk);
        chk32("oob_pre_rdata0", rdata0, 32'd7);
        chk1("oob_gnt0", gnt0, 1'b1);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk1("oob_mem_read", mem_read, 1'b0);
        chk1("oob_busy", busy, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("oob_err0", err0, 1'b1);
        chk1("oob_err1", err1, 1'b0);
        chk1("oob_rvalid0", rvalid0, 1'b1);
        chk32("oob_rdata0", rdata0, 32'd0);
        @(posedge clk); #1;
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        for (int a = 0; a < 64; a++) begin
            shadow[a] = $urandom;
            preload(6'(a), shadow[a]);
        end
        m_busy = 1'b0; m_we = 1'b0; m_port = 0; m_last = 1; m_addr = '0; m_wd = '0;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!q_req[p] && ($urandom_range(0, 2) != 0)) begin
                    q_req[p]  = 1'b1;
                    q_we[p]   = 1'($urandom_range(0, 1));
                    q_addr[p] = 8'($urandom_range(0, 255));
                    q_wd[p]   = $urandom;
                end
            end
            req0 = q_req[0]; we0 = q_we[0]; addr0 = q_addr[0]; wdata0 = q_wd[0];
            req1 = q_req[1]; we1 = q_we[1]; addr1 = q_addr[1]; wdata1 = q_wd[1];
            @(negedge clk);
            win = -1;
            if (!m_busy) begin
                if (q_req[0] && q_req[1]) win = (m_last == 0) ? 1 : 0;
                else if (q_req[0]) win = 0;
                else if (q_req[1]) win = 1;
            end
            in_r = !BOUNDS || (m_addr < 8'd64);
            chk1("rnd_gnt0", gnt0, win == 0);
            chk1("rnd_gnt1", gnt1, win == 1);
            chk1("rnd_busy", busy, m_busy);
            chk1("rnd_mem_write", mem_write, m_busy && m_we && in_r);
            chk1("rnd_mem_read", mem_read, m_busy && !m_we && in_r);
            chk1("rnd_rvalid0", rvalid0, m_rv[0]);
            chk1("rnd_rvalid1", rvalid1, m_rv[1]);
            chk32("rnd_rdata0", rdata0, m_rd[0]);
            chk32("rnd_rdata1", rdata1, m_rd[1]);
`ifdef DMEM_ARB_BOUNDS_EN
            chk1("rnd_err0", err0, m_err[0]);
            chk1("rnd_err1", err1, m_err[1]);
`endif
            if (m_busy) begin
                chk32("rnd_mem_addr", 32'(mem_addr), 32'(m_addr % 8'd64));
                if (m_we) chk32("rnd_mem_wdata", mem_wdata, m_wd);
            end
            m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0;
            if (m_busy) begin
                if (m_we) begin
                    if (in_r) shadow[m_addr % 8'd64] = m_wd;
                end else begin
                    m_rd[m_port] = in_r ? shadow[m_addr % 8'd64] : 32'd0;
                    m_rv[m_port] = 1'b1;
                end
                m_err[m_port] = !in_r;
                m_busy = 1'b0;
            end else if (win >= 0) begin
                m_busy = 1'b1;
                m_port = win;
                m_we   = q_we[win];
                m_addr = q_addr[win];
                m_wd   = q_wd[win];
                m_last = win;
                q_req[win] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (64 x 32, async read, write on posedge clk).
- Port 0 is the CPU load/store path; port 1 is the program/data loader or debug path.
- Serialises accesses through a 2-state FSM with round-robin fairness, registers read data back to the winning requester, and optionally range-checks addresses.

Parameters:
- ADDR_W, 8: requester address width (word address).
- MEM_AW, 6: memory address width; memory depth = 2**MEM_AW words.
- DATA_W, 32: data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 request; held high until gnt0
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  ADDR_W  port 0 word address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 request accepted (1-cycle pulse)
- rvalid0  out  1  port 0 read data valid (1-cycle pulse)
- rdata0  out  DATA_W  port 0 read data, held until next port 0 read completes
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  MEM_AW  to memory addr
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out (combinational)
- busy  out  1  FSM in ACCESS

Behaviour:
- Reset values: state=IDLE, last=1 (port 0 wins the first tie).
- Reset values of outputs: gnt*=0, rvalid*=0, rdata*=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, busy=0.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant it.
  - If both req, grant the port != last.
  - On grant: gnt_N=1 combinationally in that cycle; latch we/addr/wdata into op regs; set last=N; go to ACCESS.
- ACCESS (exactly 1 cycle, then always IDLE):
  - mem_addr = op_addr[MEM_AW-1:0]; mem_wdata = op_wdata; mem_write = op_we; mem_read = !op_we.
  - Read: capture mem_rdata into rdata_N at the end of ACCESS; rvalid_N=1 in the following cycle.
  - Write: commits at the ACCESS->IDLE edge; no rvalid.
  - Outside ACCESS: mem_read and mem_write are 0, mem_addr/mem_wdata hold their last values.
- Latency: req seen in cycle T (IDLE) -> gnt T -> ACCESS T+1 -> rvalid T+2. Peak throughput is one access per 2 cycles.
- rvalid of one port may coincide with gnt of the other port (or of the same port) in the IDLE cycle after ACCESS.
- req arriving during ACCESS is not granted until the next IDLE cycle. Requesters must hold req/we/addr/wdata stable until gnt. Inputs after gnt are don't-care.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1...
- Reset mid-operation: mem_write and mem_read are gated by !rst. A write in ACCESS while rst=1 must not commit. rvalid is not issued for an aborted read.
- Address truncation: without the optional feature, upper address bits beyond MEM_AW are ignored (wrap modulo depth).

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_EN.
- Enabled:
  - Adds outputs err0 and err1 (1 bit each).
  - If the latched op_addr >= 2**MEM_AW, ACCESS drives mem_read=mem_write=0.
  - err_N pulses in the cycle after ACCESS.
  - A read flagged this way also pulses rvalid_N with rdata_N=0; memory is untouched.
- Disabled: err ports absent; addresses wrap as described above.

Test Plan:
- Single write, then read: port 0 write addr 5 data 0xDEADBEEF -> gnt0 in T, mem_write=1 in T+1 only. Port 0 read addr 5 -> rvalid0 two cycles after req, rdata0=0xDEADBEEF.
- Contention: req0 and req1 both reading (addr 0 = 1, addr 1 = 7), held high from reset release -> gnt0 first, then gnt1. rdata0=1 and rdata1=7; grants alternate over 6 accesses.
- Round-robin after port 1 is last: port 1 granted alone, then both request -> port 0 granted.
- Reset mid-write: port 1 write addr 3 data 0x55; assert rst in the ACCESS cycle -> mem_write=0 and addr 3 unchanged. FSM is in IDLE with all outputs at reset values next cycle.
- Wrap, feature off: write addr 0x45 data 0x11 -> memory word 5 = 0x11.
- Out of range, feature on: read addr 0x45 -> no mem_read in ACCESS, err0=1, rvalid0=1, rdata0=0.
